// File: rtl/kbd_note_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kbd_note_pkg
// Purpose  : Shared widths and PS/2 set-2 scancodes for the keyboard note path.
// Revision : 1.0 - initial release
// ============================================================================
package kbd_note_pkg;

  localparam int NOTE_W = 7;
  localparam int OCT_W  = 3;

  // Piano row: A W S E D F T G Y H U J K -> semitones 0..12
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;

  localparam logic [7:0] SC_OCT_DN = 8'h1A;
  localparam logic [7:0] SC_OCT_UP = 8'h22;
  localparam logic [7:0] SC_GATE   = 8'h29;

endpackage
`default_nettype wire

// File: rtl/kbd_note_lut.sv
`default_nettype none
// ============================================================================
// Module   : kbd_note_lut
// Purpose  : Combinational scancode decode into note/octave/gate actions.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_note_lut
  import kbd_note_pkg::*;
(
  input  logic [7:0] scancode,
  output logic       hit,
  output logic [3:0] semitone,
  output logic       oct_dn,
  output logic       oct_up,
  output logic       gate_tgl
);

  always_comb begin
    hit      = 1'b0;
    semitone = 4'd0;
    oct_dn   = 1'b0;
    oct_up   = 1'b0;
    gate_tgl = 1'b0;
    case (scancode)
      SC_A:      begin hit = 1'b1; semitone = 4'd0;  end
      SC_W:      begin hit = 1'b1; semitone = 4'd1;  end
      SC_S:      begin hit = 1'b1; semitone = 4'd2;  end
      SC_E:      begin hit = 1'b1; semitone = 4'd3;  end
      SC_D:      begin hit = 1'b1; semitone = 4'd4;  end
      SC_F:      begin hit = 1'b1; semitone = 4'd5;  end
      SC_T:      begin hit = 1'b1; semitone = 4'd6;  end
      SC_G:      begin hit = 1'b1; semitone = 4'd7;  end
      SC_Y:      begin hit = 1'b1; semitone = 4'd8;  end
      SC_H:      begin hit = 1'b1; semitone = 4'd9;  end
      SC_U:      begin hit = 1'b1; semitone = 4'd10; end
      SC_J:      begin hit = 1'b1; semitone = 4'd11; end
      SC_K:      begin hit = 1'b1; semitone = 4'd12; end
      SC_OCT_DN: oct_dn   = 1'b1;
      SC_OCT_UP: oct_up   = 1'b1;
      SC_GATE:   gate_tgl = 1'b1;
      default:   hit      = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/kbd_note_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kbd_note_ctrl
// Purpose  : Turns a level-held release scancode into note/octave/gate updates
//            with a one-cycle note strobe.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_note_ctrl
  import kbd_note_pkg::*;
#(
  parameter int unsigned OCT_DEFAULT = 4,
  parameter int unsigned OCT_MIN     = 0,
  parameter int unsigned OCT_MAX     = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        scancode,
  output logic [NOTE_W-1:0] note,
  output logic              note_stb,
  output logic              gate,
  output logic [OCT_W-1:0]  octave
);

  localparam logic [OCT_W-1:0]  c_oct_default = OCT_W'(OCT_DEFAULT);
  localparam logic [OCT_W-1:0]  c_oct_min     = OCT_W'(OCT_MIN);
  localparam logic [OCT_W-1:0]  c_oct_max     = OCT_W'(OCT_MAX);
  localparam logic [NOTE_W-1:0] c_note_reset  = NOTE_W'(60);

  logic [7:0] prev_q;
  logic       evt_q;
  logic [7:0] code_q;

  logic       w_hit;
  logic [3:0] w_semitone;
  logic       w_oct_dn;
  logic       w_oct_up;
  logic       w_gate_tgl;
  logic [7:0] w_note_full;

  kbd_note_lut u_lut (
    .scancode (code_q),
    .hit      (w_hit),
    .semitone (w_semitone),
    .oct_dn   (w_oct_dn),
    .oct_up   (w_oct_up),
    .gate_tgl (w_gate_tgl)
  );

  // Max 12*8+12 = 108, so the 8-bit result always fits the 7-bit note.
  assign w_note_full = (8'(octave) + 8'd1) * 8'd12 + 8'(w_semitone);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= 8'h00;
      evt_q    <= 1'b0;
      code_q   <= 8'h00;
      note     <= c_note_reset;
      note_stb <= 1'b0;
      gate     <= 1'b0;
      octave   <= c_oct_default;
    end else begin
      prev_q   <= scancode;
      evt_q    <= (scancode != prev_q);
      code_q   <= scancode;
      note_stb <= 1'b0;
      if (evt_q) begin
        if (w_hit) begin
          note     <= w_note_full[NOTE_W-1:0];
          gate     <= 1'b1;
          note_stb <= 1'b1;
        end else if (w_oct_dn) begin
          if (octave > c_oct_min) octave <= octave - 1'b1;
        end else if (w_oct_up) begin
          if (octave < c_oct_max) octave <= octave + 1'b1;
        end else if (w_gate_tgl) begin
          gate <= ~gate;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_note_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_note_ctrl
// Purpose  : Table, directed and random checks of kbd_note_ctrl against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_note_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] scancode;
  logic [6:0] note;
  logic       note_stb;
  logic       gate;
  logic [2:0] octave;

  kbd_note_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scancode (scancode),
    .note     (note),
    .note_stb (note_stb),
    .gate     (gate),
    .octave   (octave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: expected outputs plus the one pending keystroke.
  logic [7:0] note_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                  8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  int         m_note, m_gate, m_oct, m_stb;
  logic [7:0] m_last;
  bit         m_pend;
  logic [7:0] m_pend_code;

  function automatic int semi_of(input logic [7:0] code);
    for (int i = 0; i < 13; i++) if (note_codes[i] == code) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_note = 60; m_gate = 0; m_oct = 4; m_stb = 0;
    m_last = 8'h00; m_pend = 1'b0; m_pend_code = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] sc);
    int s;
    m_stb = 0;
    if (m_pend) begin
      s = semi_of(m_pend_code);
      if (s >= 0) begin
        m_note = (12 * (m_oct + 1) + s) % 128;
        m_gate = 1;
        m_stb  = 1;
      end else if (m_pend_code == 8'h1A) begin
        if (m_oct > 0) m_oct = m_oct - 1;
      end else if (m_pend_code == 8'h22) begin
        if (m_oct < 7) m_oct = m_oct + 1;
      end else if (m_pend_code == 8'h29) begin
        m_gate = 1 - m_gate;
      end
    end
    m_pend      = (sc != m_last);
    m_pend_code = sc;
    m_last      = sc;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".note"},     int'(note),     m_note);
    chk({tag, ".gate"},     int'(gate),     m_gate);
    chk({tag, ".octave"},   int'(octave),   m_oct);
    chk({tag, ".note_stb"}, int'(note_stb), m_stb);
  endtask

  // Present one scancode for one clock, then compare against the model.
  task automatic step(input logic [7:0] sc, input string tag);
    scancode = sc;
    @(posedge clk);
    model_edge(sc);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    logic [7:0] sc;
    int         note;
    int         gate;
    int         oct;
    int         stb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] sc, input int n, input int g, input int o, input int s);
    vec_t v;
    v.sc = sc; v.note = n; v.gate = g; v.oct = o; v.stb = s;
    vecs.push_back(v);
  endtask

  logic [7:0] pool [20] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                            8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h1A,
                            8'h22, 8'h29, 8'h00, 8'hF0, 8'h15, 8'h22};

  initial begin
    int stb_seen;

    // Table: each row is the scancode held for one clock and the outputs after it.
    add(8'h00, 60, 0, 4, 0);
    add(8'h1C, 60, 0, 4, 0);
    add(8'h1C, 60, 1, 4, 1);
    add(8'h1C, 60, 1, 4, 0);
    add(8'h1A, 60, 1, 4, 0);
    add(8'h1C, 60, 1, 3, 0);
    add(8'h00, 48, 1, 3, 1);
    add(8'h33, 48, 1, 3, 0);
    add(8'h29, 57, 1, 3, 1);
    add(8'h00, 57, 0, 3, 0);
    add(8'h29, 57, 0, 3, 0);
    add(8'h15, 57, 1, 3, 0);
    add(8'h1C, 57, 1, 3, 0);
    add(8'h1C, 48, 1, 3, 1);
    add(8'h22, 48, 1, 3, 0);
    add(8'h33, 48, 1, 4, 0);
    add(8'h33, 69, 1, 4, 1);
    add(8'h29, 69, 1, 4, 0);
    add(8'h29, 69, 0, 4, 0);
    add(8'h00, 69, 0, 4, 0);
    add(8'h29, 69, 0, 4, 0);
    add(8'h29, 69, 1, 4, 0);

    scancode = 8'h00;
    reset_n  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.note",     int'(note),     60);
    chk("reset.gate",     int'(gate),     0);
    chk("reset.octave",   int'(octave),   4);
    chk("reset.note_stb", int'(note_stb), 0);
    reset_n = 1'b1;

    // Idle on 00: nothing may ever strobe.
    stb_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(8'h00, "idle");
      stb_seen += int'(note_stb);
    end
    chk("idle.stb_count", stb_seen, 0);

    foreach (vecs[i]) begin
      step(vecs[i].sc, "tbl_model");
      chk($sformatf("tbl[%0d].note", i),     int'(note),     vecs[i].note);
      chk($sformatf("tbl[%0d].gate", i),     int'(gate),     vecs[i].gate);
      chk($sformatf("tbl[%0d].octave", i),   int'(octave),   vecs[i].oct);
      chk($sformatf("tbl[%0d].note_stb", i), int'(note_stb), vecs[i].stb);
    end

    // Octave down saturates at 0, then the lowest A is note 12.
    for (int i = 0; i < 6; i++) begin
      step(8'h1A, "oct_dn");
      step(8'h00, "oct_dn");
    end
    step(8'h1C, "low_a");
    step(8'h00, "low_a");
    step(8'h00, "low_a");
    chk("sat_lo.octave", int'(octave), 0);
    chk("sat_lo.note",   int'(note),   12);

    // Octave up saturates at 7, top K gives the maximum note 108.
    for (int i = 0; i < 9; i++) begin
      step(8'h22, "oct_up");
      step(8'h00, "oct_up");
    end
    step(8'h42, "top_k");
    step(8'h00, "top_k");
    step(8'h00, "top_k");
    chk("sat_hi.octave", int'(octave), 7);
    chk("sat_hi.note",   int'(note),   108);

    // Back-to-back changes: every cycle carries a new code.
    step(8'h1A, "b2b");
    step(8'h1C, "b2b");
    step(8'h22, "b2b");
    step(8'h1D, "b2b");
    step(8'h29, "b2b");
    step(8'h29, "b2b");
    step(8'h29, "b2b");

    // Reset lands while the J key event is pending; it must be discarded.
    step(8'h00, "pre_rst");
    step(8'h3B, "pre_rst");
    reset_n  = 1'b0;
    scancode = 8'h00;
    #1;
    model_reset();
    chk("midrst.note",     int'(note),     60);
    chk("midrst.gate",     int'(gate),     0);
    chk("midrst.octave",   int'(octave),   4);
    chk("midrst.note_stb", int'(note_stb), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    stb_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(8'h00, "post_rst");
      stb_seen += int'(note_stb);
    end
    chk("post_rst.stb_count", stb_seen, 0);

    // A nonzero code held through reset release yields exactly one event.
    reset_n  = 1'b0;
    scancode = 8'h1C;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    stb_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(8'h1C, "held_rel");
      stb_seen += int'(note_stb);
    end
    chk("held_rel.stb_count", stb_seen, 1);
    chk("held_rel.note",      int'(note), 60);

    // Random key traffic with random hold lengths.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] sc;
      int         hold;
      sc   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) step(sc, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kbd_note_ctrl.md
Name: kbd_note_ctrl

Overview:
- Sits directly downstream of the PS/2 keyboard protocol stage and consumes its 8-bit release-only scancode output, which holds its last value.
- Detects each new scancode and maps it to a musical note number, an octave setting and a gate level for the synth voice.
- Gives the downstream oscillator/envelope stages a clean note-change strobe instead of a level-held byte.

Parameters:
- OCT_DEFAULT, 4, octave loaded at reset (range OCT_MIN..OCT_MAX).
- OCT_MIN, 0, lowest selectable octave.
- OCT_MAX, 7, highest selectable octave.

Ports:
- clk  input  1  system clock, same domain as the protocol stage.
- reset_n  input  1  asynchronous, active-low reset.
- scancode  input  8  release scancode from the protocol stage; level-held.
- note  output  7  current note number, MIDI numbering.
- note_stb  output  1  one-cycle pulse when note is (re)loaded.
- gate  output  1  voice gate level.
- octave  output  3  current octave setting.

Behaviour:
- Reset values: note=60, note_stb=0, gate=0, octave=OCT_DEFAULT, prev_q=8'h00, evt_q=0, code_q=8'h00.
- Change detect:
  - At every clk edge, prev_q<=scancode.
  - evt_q<=(scancode!=prev_q), and code_q<=scancode.
- A repeated release of the same key produces no event. This is the decided behaviour: the upstream stage gives no fresh indication.
- Action stage: on the edge after evt_q=1, act on code_q. Latency is 2 clk edges from the first edge that samples the new scancode to the updated outputs.
- Note keys (scancode set 2), mapped to semitone s:
  - 1C=0, 1D=1, 1B=2, 24=3, 23=4, 2B=5, 2C=6, 34=7, 35=8, 33=9, 3C=10, 3B=11, 42=12.
- On a note key:
  - note<=12*(octave+1)+s.
  - gate<=1.
  - note_stb<=1 for exactly one cycle.
- Octave down, 1A: octave<=octave-1, saturating at OCT_MIN.
- Octave up, 22: octave<=octave+1, saturating at OCT_MAX.
- Octave keys do not change note, gate or note_stb; the new octave applies from the next note key.
- Space, 29: gate<=~gate. No strobe; note unchanged.
- Any other code (including 00 and F0): no action. prev_q still tracks it, so the following key is always detected.
- Arithmetic: unsigned. The maximum is 12*8+12=108, which fits in 7 bits. Compute in 8 bits and truncate.
- note_stb is deasserted on every cycle without a note-key action, including cycles with an octave or space action.
- Reset mid-operation: all registers return to their reset values immediately (asynchronous). The first scancode after reset release is compared against 00.
  - A held nonzero scancode at reset release therefore produces one event, which is accepted behaviour.
- Back-to-back changes on consecutive cycles are each processed in order, one action per cycle; no event is lost.

Decomposition:
- Package kbd_note_pkg holds:
  - The scancode localparams: SC_A..SC_K, SC_OCT_DN=8'h1A, SC_OCT_UP=8'h22, SC_GATE=8'h29.
  - NOTE_W=7 and OCT_W=3.
- Sub-module kbd_note_lut: combinational scancode[7:0] -> {hit, semitone[3:0], oct_dn, oct_up, gate_tgl}. It keeps the decode table separate from the sequential control.

Test Plan:
- Reset with scancode=00, then hold 00 for 20 cycles -> note=60, gate=0, octave=4, note_stb never asserted.
- scancode 00->1C -> exactly 2 edges later note=60, gate=1, note_stb high for 1 cycle. Holding 1C further produces no more strobes.
- Sequence 1A,1C -> octave=3, note=48. Apply 1A five more times, then 1C -> octave saturates at 0, note=12. Apply 22 nine times, then 42 -> octave=7, note=108.
- Note 33 (note=69, gate=1), then 29 -> gate=0, note stays 69, no strobe. Then 29 again -> gate=1.
- Unmapped code 15, then 1C -> code 15 gives no change and no strobe. 1C is still detected: note_stb pulses, note=60.
- Assert reset_n low during the cycle evt_q=1 for a 3B key -> outputs go to reset values at once, and no strobe appears after reset release unless scancode differs from 00.
